// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for one single-port SRAM shared by instruction fetch
// (read-only) and the MEM stage (load/store). MEM has fixed priority over IF.
// Each access holds the SRAM signals for RAM_LAT cycles, then returns data with
// a one-cycle ready pulse in a RESP bubble cycle before the next grant.
module sram_port_arbiter #(
  parameter int RAM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [DATA_W-1:0]     if_rdata_o,
  output logic                  if_ready_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic [DATA_W/8-1:0]   mem_sel_i,
  output logic [DATA_W-1:0]     mem_rdata_o,
  output logic                  mem_ready_o,
  input  logic                  flush_i,
  output logic                  sram_ce_o,
  output logic                  sram_we_o,
  output logic [ADDR_W-1:0]     sram_addr_o,
  output logic [DATA_W-1:0]     sram_wdata_o,
  output logic [DATA_W/8-1:0]   sram_sel_o,
  input  logic [DATA_W-1:0]     sram_rdata_i,
  output logic                  stallreq_o
);

  localparam int SEL_W = DATA_W / 8;
  // Counter value seen in the final access cycle (RAM_LAT is 1..15).
  localparam logic [3:0] LAST_CNT = 4'(RAM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  state_t              state_reg;
  state_t              state_next;
  owner_t              owner_reg;
  logic [3:0]          cnt_reg;
  logic                kill_reg;
  logic                grant_mem;
  logic                grant_if;
  logic                last_cnt;

  logic                sram_ce_reg;
  logic                sram_we_reg;
  logic [ADDR_W-1:0]   sram_addr_reg;
  logic [DATA_W-1:0]   sram_wdata_reg;
  logic [SEL_W-1:0]    sram_sel_reg;
  logic [DATA_W-1:0]   if_rdata_reg;
  logic [DATA_W-1:0]   mem_rdata_reg;
  logic                if_ready_reg;
  logic                mem_ready_reg;

  assign last_cnt = (cnt_reg == LAST_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and fixed-priority grant (MEM first, grants only in IDLE).
  always_comb begin
    state_next = state_reg;
    grant_mem  = 1'b0;
    grant_if   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_req_i) begin
          grant_mem  = 1'b1;
          state_next = ACCESS;
        end else if (if_req_i) begin
          grant_if   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (last_cnt) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch the granted request, time the access, capture read data
  // and raise the owner's ready pulse for the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg      <= OWN_NONE;
      cnt_reg        <= 4'd0;
      kill_reg       <= 1'b0;
      sram_ce_reg    <= 1'b0;
      sram_we_reg    <= 1'b0;
      sram_addr_reg  <= '0;
      sram_wdata_reg <= '0;
      sram_sel_reg   <= '0;
      if_rdata_reg   <= '0;
      mem_rdata_reg  <= '0;
      if_ready_reg   <= 1'b0;
      mem_ready_reg  <= 1'b0;
    end else begin
      if_ready_reg  <= 1'b0;
      mem_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          kill_reg <= 1'b0;
          cnt_reg  <= 4'd0;
          if (grant_mem) begin
            owner_reg      <= OWN_MEM;
            sram_ce_reg    <= 1'b1;
            sram_we_reg    <= mem_we_i;
            sram_addr_reg  <= mem_addr_i;
            sram_wdata_reg <= mem_wdata_i;
            sram_sel_reg   <= mem_sel_i;
          end else if (grant_if) begin
            // Fetches are always full-word reads.
            owner_reg      <= OWN_IF;
            sram_ce_reg    <= 1'b1;
            sram_we_reg    <= 1'b0;
            sram_addr_reg  <= if_addr_i;
            sram_wdata_reg <= '0;
            sram_sel_reg   <= '1;
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (owner_reg == OWN_IF && flush_i) kill_reg <= 1'b1;
          if (last_cnt) begin
            sram_ce_reg <= 1'b0;
            sram_we_reg <= 1'b0;
            if (owner_reg == OWN_MEM) begin
              mem_rdata_reg <= sram_we_reg ? '0 : sram_rdata_i;
              mem_ready_reg <= 1'b1;
            end else if (owner_reg == OWN_IF) begin
              if_rdata_reg  <= sram_rdata_i;
              // A flush in this final cycle must also suppress the pulse.
              if_ready_reg  <= ~(kill_reg | flush_i);
            end
          end
        end
        RESP: begin
          owner_reg <= OWN_NONE;
          kill_reg  <= 1'b0;
        end
        default: begin
          owner_reg <= OWN_NONE;
        end
      endcase
    end
  end

  assign sram_ce_o    = sram_ce_reg;
  assign sram_we_o    = sram_we_reg;
  assign sram_addr_o  = sram_addr_reg;
  assign sram_wdata_o = sram_wdata_reg;
  assign sram_sel_o   = sram_sel_reg;
  assign if_rdata_o   = if_rdata_reg;
  assign mem_rdata_o  = mem_rdata_reg;
  assign if_ready_o   = if_ready_reg;
  assign mem_ready_o  = mem_ready_reg;

  assign stallreq_o = (mem_req_i & ~mem_ready_reg) | (if_req_i & ~if_ready_reg);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: one instance at RAM_LAT=2 for the
// directed transactions and one at RAM_LAT=1 for back-to-back fetches.
module tb_sram_port_arbiter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;

  exp_t if_q[$];
  exp_t mem_q[$];
  exp_t b_q[$];

  // Instance A (RAM_LAT=2)
  logic        if_req, mem_req, mem_we, flush;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, sram_ce, sram_we, stallreq;
  logic [3:0]  sram_sel;

  // Instance B (RAM_LAT=1), fetch port only
  logic        b_if_req;
  logic [31:0] b_if_addr, b_if_rdata, b_mem_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata;
  logic        b_if_ready, b_mem_ready, b_sram_ce, b_sram_we, b_stallreq;
  logic [3:0]  b_sram_sel;

  // SRAM contents model
  function automatic logic [31:0] sram_data(input logic [31:0] a);
    case (a)
      32'h1C000000: return 32'h02800421;
      32'h00000100: return 32'hDEADBEEF;
      default:      return a ^ 32'hA5A50000;
    endcase
  endfunction

  assign sram_rdata   = sram_ce ? sram_data(sram_addr) : 32'h0;
  assign b_sram_rdata = b_sram_ce ? sram_data(b_sram_addr) : 32'h0;

  sram_port_arbiter #(.RAM_LAT(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_sel_i(mem_sel), .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
    .flush_i(flush),
    .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_sel_o(sram_sel), .sram_rdata_i(sram_rdata),
    .stallreq_o(stallreq)
  );

  sram_port_arbiter #(.RAM_LAT(1), .ADDR_W(32), .DATA_W(32)) dut_lat1 (
    .clk(clk), .rst(rst),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_rdata_o(b_if_rdata), .if_ready_o(b_if_ready),
    .mem_req_i(1'b0), .mem_we_i(1'b0), .mem_addr_i(32'h0), .mem_wdata_i(32'h0),
    .mem_sel_i(4'h0), .mem_rdata_o(b_mem_rdata), .mem_ready_o(b_mem_ready),
    .flush_i(1'b0),
    .sram_ce_o(b_sram_ce), .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr),
    .sram_wdata_o(b_sram_wdata), .sram_sel_o(b_sram_sel), .sram_rdata_i(b_sram_rdata),
    .stallreq_o(b_stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench cycle counter, advances on every rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s = 0x%08h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got pulse, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: pop and compare whenever a ready pulse is presented
  always @(negedge clk) begin : monitor
    exp_t e;
    if (if_ready) begin
      if (if_q.size() == 0) unexpected("a_if_ready");
      else begin
        e = if_q.pop_front();
        check("a_if_rdata", if_rdata, e.data);
        check("a_if_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (mem_ready) begin
      if (mem_q.size() == 0) unexpected("a_mem_ready");
      else begin
        e = mem_q.pop_front();
        check("a_mem_rdata", mem_rdata, e.data);
        check("a_mem_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (b_if_ready) begin
      if (b_q.size() == 0) unexpected("b_if_ready");
      else begin
        e = b_q.pop_front();
        check("b_if_rdata", b_if_rdata, e.data);
        check("b_if_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (b_mem_ready) unexpected("b_mem_ready");
    if (b_sram_ce) check("b_sram_we", {31'h0, b_sram_we}, 32'h0);
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0;
    cyc = 0; vectors = 0; miscompares = 0;
    rst = 1'b0;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    mem_sel = 0; flush = 0; b_if_req = 0; b_if_addr = 0;

    // Reset state
    next_cycle(); mid();
    check("rst_sram_ce", {31'h0, sram_ce}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_stallreq", {31'h0, stallreq}, 32'h0);
    next_cycle(); rst = 1'b1;
    next_cycle();

    // 1: single fetch
    next_cycle(); t0 = cyc;
    if_req = 1; if_addr = 32'h1C000000;
    if_q.push_back('{32'h02800421, t0 + 3});
    mid(); check("t1_c0_stall", {31'h0, stallreq}, 32'h1);
           check("t1_c0_ce", {31'h0, sram_ce}, 32'h0);
    next_cycle(); mid();
    check("t1_c1_ce", {31'h0, sram_ce}, 32'h1);
    check("t1_c1_addr", sram_addr, 32'h1C000000);
    check("t1_c1_sel", {28'h0, sram_sel}, 32'hF);
    check("t1_c1_stall", {31'h0, stallreq}, 32'h1);
    next_cycle(); mid();
    check("t1_c2_ce", {31'h0, sram_ce}, 32'h1);
    check("t1_c2_stall", {31'h0, stallreq}, 32'h1);
    next_cycle(); mid();
    check("t1_c3_ce", {31'h0, sram_ce}, 32'h0);
    check("t1_c3_stall", {31'h0, stallreq}, 32'h0);
    next_cycle(); if_req = 0;
    next_cycle();

    // 2: simultaneous requests, MEM load first then fetch
    next_cycle(); t0 = cyc;
    if_req = 1; if_addr = 32'h1C000004;
    mem_req = 1; mem_we = 0; mem_addr = 32'h100; mem_sel = 4'hF;
    mem_q.push_back('{32'hDEADBEEF, t0 + 3});
    if_q.push_back('{32'hB9A50004, t0 + 7});
    mid(); check("t2_c0_stall", {31'h0, stallreq}, 32'h1);
    next_cycle(); mid();
    check("t2_c1_addr", sram_addr, 32'h00000100);
    repeat (3) next_cycle();
    mem_req = 0;
    mid(); check("t2_c4_ce", {31'h0, sram_ce}, 32'h0);
    next_cycle(); mid();
    check("t2_c5_ce", {31'h0, sram_ce}, 32'h1);
    check("t2_c5_addr", sram_addr, 32'h1C000004);
    repeat (3) next_cycle();
    if_req = 0;
    next_cycle();

    // 3: store, with a flush that must not affect a MEM access
    next_cycle(); t0 = cyc;
    mem_req = 1; mem_we = 1; mem_addr = 32'h104; mem_wdata = 32'h12345678; mem_sel = 4'b0011;
    mem_q.push_back('{32'h00000000, t0 + 3});
    next_cycle(); flush = 1; mid();
    check("t3_c1_we", {31'h0, sram_we}, 32'h1);
    check("t3_c1_addr", sram_addr, 32'h00000104);
    check("t3_c1_wdata", sram_wdata, 32'h12345678);
    check("t3_c1_sel", {28'h0, sram_sel}, 32'h3);
    next_cycle(); mid();
    check("t3_c2_we", {31'h0, sram_we}, 32'h1);
    next_cycle(); flush = 0; mid();
    check("t3_c3_we", {31'h0, sram_we}, 32'h0);
    next_cycle(); mem_req = 0;   // mem_we/mem_sel intentionally left as store values
    next_cycle();

    // 4: fetch flushed in its second access cycle, then a fresh fetch
    next_cycle(); t0 = cyc;
    if_req = 1; if_addr = 32'h1C000008;
    next_cycle(); mid();
    check("t4_c1_we", {31'h0, sram_we}, 32'h0);
    check("t4_c1_sel", {28'h0, sram_sel}, 32'hF);
    next_cycle(); flush = 1;
    next_cycle(); flush = 0; if_req = 0;
    mid(); check("t4_c3_ce", {31'h0, sram_ce}, 32'h0);
    next_cycle(); t0 = cyc;
    if_req = 1; if_addr = 32'h1C00000C;
    if_q.push_back('{32'hB9A5000C, t0 + 3});
    repeat (4) next_cycle();
    if_req = 0;
    next_cycle();

    // 5: asynchronous reset in the middle of an access
    next_cycle();
    if_req = 1; if_addr = 32'h1C000010;
    next_cycle();
    #2; rst = 1'b0; if_req = 0;
    #1;
    check("t5_sram_ce", {31'h0, sram_ce}, 32'h0);
    check("t5_sram_addr", sram_addr, 32'h0);
    check("t5_sram_sel", {28'h0, sram_sel}, 32'h0);
    check("t5_sram_wdata", sram_wdata, 32'h0);
    check("t5_if_rdata", if_rdata, 32'h0);
    check("t5_mem_rdata", mem_rdata, 32'h0);
    check("t5_stallreq", {31'h0, stallreq}, 32'h0);
    next_cycle(); next_cycle();
    rst = 1'b1;
    repeat (6) next_cycle();

    // 6: RAM_LAT=1, ten back-to-back fetches, one pulse every 3 cycles
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      b_if_req  = 1;
      b_if_addr = 32'h1C000020 + 32'(i * 4);
      b_q.push_back('{(32'h1C000020 + 32'(i * 4)) ^ 32'hA5A50000, cyc + 2});
      next_cycle();
      next_cycle();
    end
    next_cycle(); b_if_req = 0;
    repeat (4) next_cycle();

    check("if_queue_empty", 32'(if_q.size()), 32'h0);
    check("mem_queue_empty", 32'(mem_q.size()), 32'h0);
    check("b_queue_empty", 32'(b_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
